audio_band_splitter: RTL and testbench

//  Three-band crossover. Splits each codec sample into low/mid/high bands for the

---
 rtl/audio_eq_pkg.sv | 30 +++
 rtl/audio_onepole_mac.sv | 33 +++
 rtl/audio_band_splitter.sv | 116 +++++++++++
 tb/tb_audio_band_splitter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_eq_pkg.sv
// Shared constants, FSM encoding and helpers for the three-band audio crossover.
// Holds the sample/fraction/coefficient widths, default filter coefficients,
// the crossover FSM state type and the band saturation helper used when
// AUDIO_BAND_SPLIT_SAT_EN is defined.
package audio_eq_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FRAC_W   = 16;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned ACC_W    = SAMPLE_W + FRAC_W;

  // ~300 Hz and ~3 kHz one-pole corners at 48 kHz
  localparam int unsigned A_LO_DEF = 2524;
  localparam int unsigned A_HI_DEF = 21300;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    S_LO  = 2'd1,
    S_HI  = 2'd2,
    S_OUT = 2'd3
  } state_t;

  // Clamp a SAMPLE_W+1 difference into the signed SAMPLE_W range
  function automatic logic signed [SAMPLE_W-1:0] sat_band(input logic signed [SAMPLE_W:0] v);
    if (v[SAMPLE_W] != v[SAMPLE_W-1])
      return v[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/audio_onepole_mac.sv
// One-pole low-pass update datapath, shared by both crossover filters.
//   acc_next_c = acc + floor(((x << FRAC_W) - acc) * coef / 2^COEF_W)
// Ports:
//   acc        in   ACC_W     current accumulator (signed, FRAC_W fraction bits)
//   x          in   SAMPLE_W  input sample (signed)
//   coef       in   COEF_W    unsigned coefficient, value coef / 2^COEF_W
//   acc_next_c out  ACC_W     updated accumulator (combinational)
module audio_onepole_mac
  import audio_eq_pkg::*;
(
  input  logic signed [ACC_W-1:0]    acc,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic        [COEF_W-1:0]   coef,
  output logic signed [ACC_W-1:0]    acc_next_c
);

  localparam int unsigned DIFF_W = ACC_W + 1;
  localparam int unsigned PROD_W = DIFF_W + COEF_W + 1;

  logic signed [ACC_W-1:0]  target;
  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] prod;

  // Coefficient is zero-extended so the product stays signed; >>> floors.
  // coef < 2^COEF_W keeps the step smaller than diff, so the sum never overflows.
  always_comb begin
    target     = $signed({x, {FRAC_W{1'b0}}});
    diff       = DIFF_W'(target) - DIFF_W'(acc);
    prod       = PROD_W'(diff) * $signed(PROD_W'({1'b0, coef}));
    acc_next_c = acc + ACC_W'(prod >>> COEF_W);
  end

endmodule

// File: rtl/audio_band_splitter.sv
// Three-band crossover: low = LP_LO, mid = LP_HI - LP_LO, high = x - LP_HI.
// Both one-pole filters share one MAC, sequenced IDLE -> S_LO -> S_HI -> S_OUT.
// Optional macro: AUDIO_BAND_SPLIT_SAT_EN saturates mid/high instead of wrapping.
// Ports:
//   clk          in   1         clock
//   rst          in   1         asynchronous reset, active-low
//   sample_valid in   1         one-cycle strobe, audio_in valid
//   audio_in     in   SAMPLE_W  signed input sample
//   overrun_clr  in   1         clears overrun
//   audio_low    out  SAMPLE_W  low band
//   audio_mid    out  SAMPLE_W  mid band
//   audio_high   out  SAMPLE_W  high band
//   bands_valid  out  1         one-cycle strobe, bands updated
//   busy         out  1         FSM not in IDLE
//   overrun      out  1         sticky, sample arrived while busy
module audio_band_splitter
  import audio_eq_pkg::*;
#(
  parameter int unsigned A_LO = A_LO_DEF,
  parameter int unsigned A_HI = A_HI_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] audio_in,
  input  logic                       overrun_clr,
  output logic signed [SAMPLE_W-1:0] audio_low,
  output logic signed [SAMPLE_W-1:0] audio_mid,
  output logic signed [SAMPLE_W-1:0] audio_high,
  output logic                       bands_valid,
  output logic                       busy,
  output logic                       overrun
);

  state_t                     state_q, state_d;
  logic signed [SAMPLE_W-1:0] x_q;
  logic signed [ACC_W-1:0]    acc_lo_q, acc_hi_q;
  logic signed [ACC_W-1:0]    mac_acc_c, mac_next_c;
  logic        [COEF_W-1:0]   mac_coef_c;
  logic signed [SAMPLE_W-1:0] lo_band_c, hi_band_c, mid_c, high_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and MAC operand selection
  always_comb begin
    state_d    = state_q;
    mac_acc_c  = acc_lo_q;
    mac_coef_c = COEF_W'(A_LO);
    unique case (state_q)
      IDLE:    if (sample_valid) state_d = S_LO;
      S_LO:    state_d = S_HI;
      S_HI: begin
        state_d    = S_OUT;
        mac_acc_c  = acc_hi_q;
        mac_coef_c = COEF_W'(A_HI);
      end
      S_OUT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  audio_onepole_mac u_mac (
    .acc        (mac_acc_c),
    .x          (x_q),
    .coef       (mac_coef_c),
    .acc_next_c (mac_next_c)
  );

  // Band arithmetic; band value is the integer part (floor) of each accumulator
  always_comb begin
    lo_band_c = acc_lo_q[ACC_W-1 -: SAMPLE_W];
    hi_band_c = acc_hi_q[ACC_W-1 -: SAMPLE_W];
`ifdef AUDIO_BAND_SPLIT_SAT_EN
    mid_c  = sat_band((SAMPLE_W+1)'(hi_band_c) - (SAMPLE_W+1)'(lo_band_c));
    high_c = sat_band((SAMPLE_W+1)'(x_q) - (SAMPLE_W+1)'(hi_band_c));
`else
    // SAMPLE_W-bit subtraction equals the low bits of the wide result (wrap)
    mid_c  = hi_band_c - lo_band_c;
    high_c = x_q - hi_band_c;
`endif
  end

  // Datapath, output registers and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q         <= '0;
      acc_lo_q    <= '0;
      acc_hi_q    <= '0;
      audio_low   <= '0;
      audio_mid   <= '0;
      audio_high  <= '0;
      bands_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      busy        <= (state_d != IDLE);
      bands_valid <= (state_q == S_OUT);
      if (state_q == IDLE && sample_valid) x_q <= audio_in;
      if (state_q == S_LO) acc_lo_q <= mac_next_c;
      if (state_q == S_HI) acc_hi_q <= mac_next_c;
      if (state_q == S_OUT) begin
        audio_low  <= lo_band_c;
        audio_mid  <= mid_c;
        audio_high <= high_c;
      end
      // A new overrun takes priority over a clear on the same edge
      if (sample_valid && state_q != IDLE) overrun <= 1'b1;
      else if (overrun_clr)                overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_band_splitter.sv
// Scoreboard bench for audio_band_splitter: a reference one-pole model predicts
// each accepted sample's bands; the monitor pops and compares on bands_valid.
module tb_audio_band_splitter;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_valid;
  logic signed [15:0] audio_in;
  logic               overrun_clr;
  logic signed [15:0] audio_low, audio_mid, audio_high;
  logic               bands_valid, busy, overrun;

  always #5 clk = ~clk;

  audio_band_splitter dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .overrun_clr  (overrun_clr),
    .audio_low    (audio_low),
    .audio_mid    (audio_mid),
    .audio_high   (audio_high),
    .bands_valid  (bands_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  typedef struct { longint low; longint mid; longint high; } exp_t;
  exp_t   sb[$];
  longint m_lo = 0, m_hi = 0;
  int     n_checks = 0, n_errors = 0;
  int     bv_count = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint onepole(input longint acc, input longint x, input longint a);
    longint diff;
    diff = x * 65536 - acc;
    return acc + ((diff * a) >>> 16);
  endfunction

  function automatic longint fit16(input longint v);
    longint w;
`ifdef AUDIO_BAND_SPLIT_SAT_EN
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    w = v & 64'hFFFF;
    if (w >= 32768) w = w - 65536;
    return w;
`endif
  endfunction

  function automatic longint absl(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_push(input longint x);
    exp_t   e;
    longint lo, hi;
    m_lo   = onepole(m_lo, x, 2524);
    m_hi   = onepole(m_hi, x, 21300);
    lo     = m_lo >>> 16;
    hi     = m_hi >>> 16;
    e.low  = lo;
    e.mid  = fit16(hi - lo);
    e.high = fit16(x - hi);
    sb.push_back(e);
  endtask

  // Drive one clock of inputs; acc says whether the DUT should take the sample
  task automatic cyc(input logic v, input logic signed [15:0] x, input logic clr, input bit acc);
    sample_valid = v;
    audio_in     = x;
    overrun_clr  = clr;
    @(posedge clk); #1;
    if (v && acc) model_push(longint'(x));
    sample_valid = 1'b0;
    overrun_clr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'sd0, 1'b0, 1'b0);
  endtask

  task automatic wait_bands(output int lat);
    bit found = 0;
    lat = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bands_valid) found = 1;
    end
    if (!found) check_eq("bands_timeout", 0, 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst && bands_valid) begin
      exp_t e;
      bv_count++;
      if (sb.size() == 0) check_eq("sb_unexpected_bands", 1, 0);
      else begin
        e = sb.pop_front();
        check_eq("sb_low",  longint'(audio_low),  e.low);
        check_eq("sb_mid",  longint'(audio_mid),  e.mid);
        check_eq("sb_high", longint'(audio_high), e.high);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c0;
    logic signed [15:0] r;
    rst = 1'b0; sample_valid = 1'b0; audio_in = '0; overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_low",     longint'(audio_low),  0);
    check_eq("rst_mid",     longint'(audio_mid),  0);
    check_eq("rst_high",    longint'(audio_high), 0);
    check_eq("rst_bv",      longint'(bands_valid), 0);
    check_eq("rst_busy",    longint'(busy), 0);
    check_eq("rst_overrun", longint'(overrun), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: single step
    cyc(1'b1, 16'sd16384, 1'b0, 1'b1);
    check_eq("t1_busy", longint'(busy), 1);
    wait_bands(lat);
    check_eq("t1_latency", longint'(lat), 3);
    check_eq("t1_low",  longint'(audio_low),  631);
    check_eq("t1_mid",  longint'(audio_mid),  4694);
    check_eq("t1_high", longint'(audio_high), 11059);
    check_eq("t1_busy_done", longint'(busy), 0);
    @(negedge clk);
    check_eq("t1_bv_one_cycle", longint'(bands_valid), 0);

    // 2: DC settling
    for (int i = 0; i < 2000; i++) begin
      cyc(1'b1, 16'sd16000, 1'b0, 1'b1);
      idle(7);
    end
    idle(4);
    check_eq("t2_low_dc",  longint'(absl(longint'(audio_low) - 16000) <= 1), 1);
    check_eq("t2_mid_dc",  longint'(absl(longint'(audio_mid)) <= 2), 1);
    check_eq("t2_high_dc", longint'(absl(longint'(audio_high)) <= 2), 1);

    // 3: overrun on back-to-back strobes, clear, set-wins, S_OUT edge drop
    c0 = bv_count;
    cyc(1'b1, 16'sd1000, 1'b0, 1'b1);
    cyc(1'b1, -16'sd1000, 1'b0, 1'b0);
    idle(8);
    check_eq("t3_one_bands", longint'(bv_count - c0), 1);
    check_eq("t3_overrun_set", longint'(overrun), 1);
    cyc(1'b0, 16'sd0, 1'b1, 1'b0);
    check_eq("t3_overrun_clr", longint'(overrun), 0);
    cyc(1'b1, 16'sd500, 1'b0, 1'b1);
    cyc(1'b1, 16'sd7, 1'b1, 1'b0);
    check_eq("t3_set_wins", longint'(overrun), 1);
    idle(6);
    cyc(1'b0, 16'sd0, 1'b1, 1'b0);
    check_eq("t3_overrun_clr2", longint'(overrun), 0);
    cyc(1'b1, 16'sd200, 1'b0, 1'b1);
    idle(2);
    cyc(1'b1, 16'sd9, 1'b0, 1'b0);
    check_eq("t3_sout_drop", longint'(overrun), 1);
    idle(6);
    cyc(1'b0, 16'sd0, 1'b1, 1'b0);
    check_eq("t3_overrun_clr3", longint'(overrun), 0);

    // 4: full-scale step, exercises saturation / wrap
    for (int i = 0; i < 2000; i++) begin
      cyc(1'b1, 16'sd32767, 1'b0, 1'b1);
      idle(3);
    end
    cyc(1'b1, 16'sh8000, 1'b0, 1'b1);
    wait_bands(lat);
`ifdef AUDIO_BAND_SPLIT_SAT_EN
    check_eq("t4_high_sat", longint'(audio_high), -32768);
`else
    check_eq("t4_high_wrap_pos", longint'(audio_high > 0), 1);
`endif
    idle(6);

    // 5: reset during S_HI
    c0 = bv_count;
    cyc(1'b1, 16'sd1234, 1'b0, 1'b1);
    idle(1);
    rst = 1'b0;
    #1;
    check_eq("t5_low",  longint'(audio_low),  0);
    check_eq("t5_mid",  longint'(audio_mid),  0);
    check_eq("t5_high", longint'(audio_high), 0);
    check_eq("t5_busy", longint'(busy), 0);
    sb.delete();
    m_lo = 0; m_hi = 0;
    repeat (3) begin
      @(negedge clk);
      check_eq("t5_no_bv_in_rst", longint'(bands_valid), 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle(5);
    check_eq("t5_no_bands", longint'(bv_count - c0), 0);
    cyc(1'b1, 16'sd16384, 1'b0, 1'b1);
    wait_bands(lat);
    check_eq("t5_latency", longint'(lat), 3);
    check_eq("t5_low",  longint'(audio_low),  631);
    check_eq("t5_mid",  longint'(audio_mid),  4694);
    check_eq("t5_high", longint'(audio_high), 11059);
    idle(4);

    // 6: maximum rate
    c0 = bv_count;
    for (int i = 0; i < 100; i++) begin
      r = 16'($urandom);
      cyc(1'b1, r, 1'b0, 1'b1);
      idle(3);
    end
    idle(6);
    check_eq("t6_bands_count", longint'(bv_count - c0), 100);
    check_eq("t6_no_overrun", longint'(overrun), 0);

    check_eq("sb_drained", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
